// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, programmable wait states,
// byte-enabled access to an internal word array, valid/ready response out.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic [3:0]        be;
   } req_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   req_t              lat;
   req_t              acc;
   logic [31:0]       mem [DEPTH_WORDS];
   logic              accept;
   logic              do_access;
   logic              acc_err;
   logic              mem_we;
   logic [ADDR_W-1:0] word_idx;
   logic [IDX_W-1:0]  idx;
   logic [31:0]       rd;

   assign req_ready = reset && (state == IDLE);
   assign accept    = req_valid && req_ready;

   // With no wait states the access happens on the acceptance edge itself,
   // so it must read the live request rather than the (not yet) latched copy.
   assign acc       = (state == IDLE) ? {req_write, req_addr, req_wdata, req_be} : lat;
   assign do_access = (accept && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == CNT_W'(1)));

   assign word_idx = {2'b00, acc.addr[ADDR_W-1:2]};
   assign idx      = word_idx[IDX_W-1:0];
   assign acc_err  = (acc.addr[1:0] != 2'b00) || (word_idx >= ADDR_W'(DEPTH_WORDS));
   assign mem_we   = do_access && acc.write && !acc_err;
   assign rd       = (acc.write || acc_err) ? '0 : mem[idx];

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (acc.be[i]) mem[idx][8*i +: 8] <= acc.wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         lat       <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  lat <= acc;
                  if (WAIT_CYCLES > 0) begin
                     cnt   <= CNT_W'(WAIT_CYCLES);
                     state <= WAIT;
                  end
               end
            end
            WAIT: cnt <= cnt - CNT_W'(1);
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         if (do_access) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rd;
            rsp_err   <= acc_err;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a 2-wait-state instance driven through a
// scoreboarded transaction task, plus a zero-wait instance for back-to-back timing.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   logic        r0_valid, r0_ready, r0_write;
   logic [31:0] r0_addr, r0_wdata;
   logic [3:0]  r0_be;
   logic        r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
   logic [31:0] r0_rsp_rdata;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [32:0] sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(r0_valid), .req_ready(r0_ready), .req_write(r0_write),
      .req_addr(r0_addr), .req_wdata(r0_wdata), .req_be(r0_be),
      .rsp_valid(r0_rsp_valid), .rsp_ready(r0_rsp_ready),
      .rsp_rdata(r0_rsp_rdata), .rsp_err(r0_rsp_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One transaction on the 2-wait instance; hold>0 keeps rsp_ready low that
   // many cycles and pokes a stray request in the middle of the stall.
   task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e,
                      input int hold);
      int          n;
      logic [32:0] exp;
      logic [31:0] d0;
      logic        e0;
      sb.push_back({exp_e, exp_d});
      @(negedge clk);
      req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
      rsp_ready = (hold == 0);
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 1;
      while (!rsp_valid && n < 10) begin
         chk("req_ready_busy", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
         n++;
      end
      chk("latency", 32'(n), 32'd3);
      exp = sb.pop_front();
      d0 = rsp_rdata; e0 = rsp_err;
      chk("rsp_rdata", rsp_rdata, exp[31:0]);
      chk("rsp_err", 32'(rsp_err), 32'(exp[32]));
      for (int k = 0; k < hold; k++) begin
         if (k == 1) begin
            req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h0; req_be = 4'hF;
            req_valid = 1'b1;
         end
         if (k == 2) req_valid = 1'b0;
         @(posedge clk); #1;
         chk("stall_valid", 32'(rsp_valid), 32'd1);
         chk("stall_rdata", rsp_rdata, d0);
         chk("stall_err", 32'(rsp_err), 32'(e0));
         chk("stall_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("done_valid", 32'(rsp_valid), 32'd0);
      chk("done_rdata", rsp_rdata, 32'd0);
      chk("done_err", 32'(rsp_err), 32'd0);
      chk("done_ready", 32'(req_ready), 32'd1);
      if (hold > 0) begin
         for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("no_stray_rsp", 32'(rsp_valid), 32'd0);
         end
      end
   endtask

   // Zero-wait instance: returns the cycle of the acceptance edge.
   task automatic acc0(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_d, output int acc_cyc);
      int n;
      @(negedge clk);
      r0_write = wr; r0_addr = addr; r0_wdata = wdata; r0_be = 4'hF; r0_valid = 1'b1;
      n = 0;
      while (!r0_ready && n < 10) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      acc_cyc  = cyc;
      r0_valid = 1'b0;
      chk("w0_rsp_valid", 32'(r0_rsp_valid), 32'd1);
      chk("w0_rdata", r0_rsp_rdata, exp_d);
      chk("w0_err", 32'(r0_rsp_err), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, t2, t3, n;
      reset = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
      rsp_ready = 1'b1;
      r0_valid = 1'b0; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0; r0_be = '0;
      r0_rsp_ready = 1'b1;
      #2;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1 chk("post_rst_ready", 32'(req_ready), 32'd1);

      // basic load with latency, preload done through the store path
      txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
      txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);

      // byte-enabled stores
      txn(1'b1, 32'h20, 32'hAAAAAAAA, 4'hF, 32'h0, 1'b0, 0);
      txn(1'b1, 32'h20, 32'h11223344, 4'b0101, 32'h0, 1'b0, 0);
      txn(1'b0, 32'h20, 32'h0, 4'h0, 32'hAA22AA44, 1'b0, 0);
      txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 0);
      txn(1'b0, 32'h20, 32'h0, 4'h0, 32'hAA22AA44, 1'b0, 0);

      // faults and the last valid word
      txn(1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1, 0);
      txn(1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 0);
      txn(1'b1, 32'h22, 32'h55555555, 4'hF, 32'h0, 1'b1, 0);
      txn(1'b0, 32'h20, 32'h0, 4'h0, 32'hAA22AA44, 1'b0, 0);
      txn(1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 0);
      txn(1'b0, 32'hFFC, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 0);

      // response backpressure with a stray request; 0x20 must be untouched
      txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 5);
      txn(1'b0, 32'h20, 32'h0, 4'h0, 32'hAA22AA44, 1'b0, 0);

      // zero-wait instance: back-to-back, two edges between acceptances
      acc0(1'b1, 32'h0, 32'hCAFE0001, 32'h0, t0);
      acc0(1'b1, 32'h4, 32'hCAFE0002, 32'h0, t1);
      acc0(1'b0, 32'h0, 32'h0, 32'hCAFE0001, t2);
      acc0(1'b0, 32'h4, 32'h0, 32'hCAFE0002, t3);
      chk("w0_spacing1", 32'(t1 - t0), 32'd2);
      chk("w0_spacing2", 32'(t2 - t1), 32'd2);
      chk("w0_spacing3", 32'(t3 - t2), 32'd2);

      // reset in WAIT of a store: the store must never land
      txn(1'b1, 32'h30, 32'h0, 4'hF, 32'h0, 1'b0, 0);
      @(negedge clk);
      req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("wait_ready", 32'(req_ready), 32'd0);
      #2 reset = 1'b0;
      #1;
      chk("arst_wait_valid", 32'(rsp_valid), 32'd0);
      chk("arst_wait_ready", 32'(req_ready), 32'd0);
      chk("arst_wait_rdata", rsp_rdata, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      txn(1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, 0);

      // reset while a response is stalled: outputs drop without a clock edge
      @(negedge clk);
      rsp_ready = 1'b0;
      req_write = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
      chk("resp_before_rst", rsp_rdata, 32'hDEADBEEF);
      @(negedge clk); #2 reset = 1'b0;
      #1;
      chk("arst_resp_valid", 32'(rsp_valid), 32'd0);
      chk("arst_resp_rdata", rsp_rdata, 32'd0);
      chk("arst_resp_ready", 32'(req_ready), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      rsp_ready = 1'b1;
      #1 chk("rel_ready", 32'(req_ready), 32'd1);
      txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
